// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data-memory responder and its storage.
package data_memory_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int LANE_COUNT = 4;
  localparam int LANE_WIDTH = WORD_WIDTH / LANE_COUNT;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_WAIT    = 2'd1,
    STATE_RESPOND = 2'd2
  } state_e;

  // Byte address to word index; callers truncate to their storage depth.
  function automatic logic [WORD_WIDTH-1:0] word_index(input logic [WORD_WIDTH-1:0] byte_address);
    return byte_address >> 2;
  endfunction

endpackage

// File: rtl/data_memory_storage.sv
// 2^ADDRESS_WIDTH x 32 RAM with per-byte-lane write enables and a registered read port.
module data_memory_storage
  import data_memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10
) (
  input  logic                     clk,
  input  logic [LANE_COUNT-1:0]    write_enable,
  input  logic                     read_enable,
  input  logic [ADDRESS_WIDTH-1:0] address,
  input  logic [WORD_WIDTH-1:0]    write_data,
  output logic [WORD_WIDTH-1:0]    read_data
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] read_data_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANE_COUNT; i++) begin
      if (write_enable[i]) begin
        mem[address][i*LANE_WIDTH +: LANE_WIDTH] <= write_data[i*LANE_WIDTH +: LANE_WIDTH];
      end
    end
  end

  // Read register only moves on a load, so data stays put while a response is held.
  always_ff @(posedge clk) begin
    if (read_enable) begin
      read_data_q <= mem[address];
    end
  end

  assign read_data = read_data_q;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one request at a time, fixed latency, byte-enabled stores.
// Optional misalignment flagging is compiled in with DATA_MEMORY_MISALIGN_CHECK_EN.
module data_memory_responder
  import data_memory_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 10,
  parameter int LATENCY       = 2
) (
  input  logic                  system_clock,
  input  logic                  reset,
  input  logic                  request_valid,
  output logic                  request_ready,
  input  logic                  request_write,
  input  logic [WORD_WIDTH-1:0] request_address,
  input  logic [WORD_WIDTH-1:0] request_write_data,
  input  logic [LANE_COUNT-1:0] request_byte_enable,
  output logic                  response_valid,
  input  logic                  response_ready,
  output logic [WORD_WIDTH-1:0] response_read_data,
  output logic                  response_error
);

  localparam logic [3:0] COUNT_START = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e                   state_q, state_d;
  logic [3:0]               count_q, count_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] index_q, index_d;
  logic [WORD_WIDTH-1:0]    data_q, data_d;
  logic [LANE_COUNT-1:0]    enable_q, enable_d;
  logic                     error_q, error_d;

  logic                     request_misaligned;
  logic [ADDRESS_WIDTH-1:0] request_index;

  logic                     access_go;
  logic                     access_write;
  logic                     access_error;
  logic [ADDRESS_WIDTH-1:0] access_index;
  logic [WORD_WIDTH-1:0]    access_data;
  logic [LANE_COUNT-1:0]    access_enable;

  logic [LANE_COUNT-1:0]    ram_write_enable;
  logic                     ram_read_enable;
  logic [WORD_WIDTH-1:0]    ram_read_data;

  assign request_index = ADDRESS_WIDTH'(word_index(request_address));

`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  assign request_misaligned = (request_address[1:0] != 2'b00);
`else
  assign request_misaligned = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    write_d       = write_q;
    index_d       = index_q;
    data_d        = data_q;
    enable_d      = enable_q;
    error_d       = error_q;
    access_go     = 1'b0;
    access_write  = write_q;
    access_error  = error_q;
    access_index  = index_q;
    access_data   = data_q;
    access_enable = enable_q;

    case (state_q)
      STATE_IDLE: begin
        if (request_valid) begin
          write_d  = request_write;
          index_d  = request_index;
          data_d   = request_write_data;
          enable_d = request_byte_enable;
          error_d  = request_misaligned;
          // Zero latency: the access happens on the accept edge straight from the inputs.
          if (LATENCY == 0) begin
            access_go     = 1'b1;
            access_write  = request_write;
            access_error  = request_misaligned;
            access_index  = request_index;
            access_data   = request_write_data;
            access_enable = request_byte_enable;
            state_d       = STATE_RESPOND;
          end else begin
            count_d = COUNT_START;
            state_d = STATE_WAIT;
          end
        end
      end
      STATE_WAIT: begin
        if (count_q == 4'd0) begin
          access_go = 1'b1;
          state_d   = STATE_RESPOND;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      STATE_RESPOND: begin
        if (response_ready) begin
          state_d = STATE_IDLE;
        end
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // Flagged accesses never touch the RAM; their read data is masked to zero below.
  assign ram_write_enable = (access_go && access_write && !access_error) ? access_enable : '0;
  assign ram_read_enable  = access_go && !access_write && !access_error;

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      state_q  <= STATE_IDLE;
      count_q  <= 4'd0;
      write_q  <= 1'b0;
      index_q  <= '0;
      data_q   <= '0;
      enable_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      write_q  <= write_d;
      index_q  <= index_d;
      data_q   <= data_d;
      enable_q <= enable_d;
      error_q  <= error_d;
    end
  end

  data_memory_storage #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_storage (
    .clk         (system_clock),
    .write_enable(ram_write_enable),
    .read_enable (ram_read_enable),
    .address     (access_index),
    .write_data  (access_data),
    .read_data   (ram_read_data)
  );

  assign request_ready      = (state_q == STATE_IDLE);
  assign response_valid     = (state_q == STATE_RESPOND);
  assign response_error     = (state_q == STATE_RESPOND) && error_q;
  assign response_read_data = (state_q == STATE_RESPOND && !write_q && !error_q) ? ram_read_data : '0;

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Responder end of the core's data-memory request/response interface, for the pipelined core's MEM stage.
- The MEM stage issues load/store requests through a valid/ready handshake. This block accepts one request at a time, applies a fixed programmable latency, commits writes with byte enables, and returns read data or write completion through a second valid/ready handshake.
- Replaces the zero-latency data memory so that the pipeline's stall logic can be exercised.

Parameters:
- ADDRESS_WIDTH, 10, number of word-index bits; storage depth is 2^ADDRESS_WIDTH 32-bit words.
- LATENCY, 2, wait cycles between request acceptance and response presentation; legal range 0..15.

Ports:
- system_clock  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- request_valid  input  1  initiator presents a request.
- request_ready  output  1  responder can accept a request.
- request_write  input  1  1 = store, 0 = load.
- request_address  input  32  byte address.
- request_write_data  input  32  store data; byte lane i is bits [8i+7:8i].
- request_byte_enable  input  4  store lane mask; ignored for loads.
- response_valid  output  1  response presented.
- response_ready  input  1  initiator accepts the response.
- response_read_data  output  32  load data; 0 for stores.
- response_error  output  1  misaligned-access error (see Optional Feature); tied 0 when the feature is compiled out.

Behaviour:
- Reset values (asynchronous assert):
  - state = IDLE, request_ready = 1, response_valid = 0, response_read_data = 0, response_error = 0, wait counter = 0.
  - Storage contents are not reset.
- States are IDLE, WAIT, RESPOND.
  - request_ready = 1 only in IDLE.
  - response_valid = 1 only in RESPOND.
- IDLE: on request_valid && request_ready, latch write flag, word index, data, byte enables, and error flag.
  - LATENCY > 0: go to WAIT with counter = LATENCY-1.
  - LATENCY = 0: go directly to RESPOND.
- WAIT: decrement the counter each cycle. At 0, perform the access and go to RESPOND the same edge.
- Access:
  - Word index = request_address[ADDRESS_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo 2^ADDRESS_WIDTH words.
  - Store: write only the enabled lanes. Byte enable 0000 leaves storage unchanged but still produces a response.
  - Load: capture the full word into response_read_data.
- RESPOND: hold response_read_data and response_error stable while response_valid = 1 and response_ready = 0. On response_ready, go to IDLE.
- Throughput and latency:
  - No overlap: a new request is accepted no earlier than the cycle after the response handshake.
  - Acceptance edge to response_valid high = LATENCY+1 cycles.
- Request fields are sampled only at the accept edge; later input changes have no effect.
- Reset mid-operation: the pending request is dropped. A store not yet committed (still in WAIT) never reaches storage.
- request_valid while not ready: ignored, no side effects; the initiator must hold it.
- response_ready while response_valid = 0: ignored.

Optional Feature:
- Macro: DATA_MEMORY_MISALIGN_CHECK_EN.
- Defined: a request with request_address[1:0] != 0 is flagged at acceptance.
  - Flagged store: does not modify storage.
  - Flagged load: returns response_read_data = 0.
  - Both respond with response_error = 1 after the normal latency.
- Undefined: request_address[1:0] is ignored, every access proceeds normally, and response_error is constant 0.

Decomposition:
- Shared package data_memory_pkg holds:
  - state enum (IDLE, WAIT, RESPOND);
  - word width 32 and lane count 4;
  - the word-index slice helper.
- One sub-module: data_memory_storage, a 2^ADDRESS_WIDTH x 32 RAM with per-lane write enable and registered read port.
- FSM, counter and handshake logic stay in data_memory_responder.

Test Plan:
- Store, then load, LATENCY=2: store 0x12345678 at 0x40 with enable 1111, then load 0x40 -> response_valid exactly 3 cycles after each accept; load returns 0x12345678.
- Byte lanes: word 0x00000000 at 0x80, store 0xAABBCCDD with enable 0101, then load -> 0x00BB00DD.
- Backpressure: hold response_ready = 0 for 5 cycles during a load -> response_valid and data held stable; request_ready = 0 throughout; one handshake occurs on release.
- Wrap-around, ADDRESS_WIDTH=10: store 0xCAFEF00D at 0x1000, then load 0x0000 -> 0xCAFEF00D.
- Reset mid-WAIT: assert reset one cycle after accepting a store of 0xFFFFFFFF to 0x20 -> response_valid = 0 and request_ready = 1 immediately; subsequent load of 0x20 returns the prior value.
- With DATA_MEMORY_MISALIGN_CHECK_EN: store to 0x42 -> response_error = 1, storage unchanged; load 0x42 -> read data 0, response_error = 1. Without the macro: the store to 0x42 writes word 0x40.
